// File: rtl/conv_sequencer.sv
// conv_sequencer: raster-scans the interior of the processing buffer and
// drives matching ALU read/write addresses into mem_controller.
module conv_sequencer #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int AW     = 17,
    parameter int RD_LAT = 2
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stall,
    output logic [AW-1:0] raddr_alu,
    output logic [AW-1:0] waddr_alu,
    output logic          wen_alu,
    output logic          busy,
    output logic          done,
    output logic          overrun,
    output logic [7:0]    frame_cnt
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [XW-1:0] X_FIRST = XW'(1);
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 2);
    localparam logic [YW-1:0] Y_FIRST = YW'(1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 2);
    localparam logic [AW-1:0] A_FIRST = AW'(IMG_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;

    logic [RD_LAT-1:0] pv;
    logic [AW-1:0]     pa [RD_LAT];

    logic issue;
    logic last_pos;
    logic tail_empty;

    assign issue    = (state == S_RUN) && !stall;
    assign last_pos = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

    // Pipe is drained once nothing is left ahead of the output stage.
    always_comb begin
        tail_empty = 1'b1;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            if (pv[i]) begin
                tail_empty = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus state-derived outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        wen_alu   = pv[RD_LAT-1] && !stall;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (issue && last_pos) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (!stall && tail_empty) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Interior raster counter; the row wrap skips two border pixels.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            raddr_alu <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
        end else if (state == S_IDLE && start) begin
            raddr_alu <= A_FIRST;
            x_cnt     <= X_FIRST;
            y_cnt     <= Y_FIRST;
        end else if (issue && !last_pos) begin
            if (x_cnt == X_LAST) begin
                raddr_alu <= raddr_alu + AW'(3);
                x_cnt     <= X_FIRST;
                y_cnt     <= y_cnt + YW'(1);
            end else begin
                raddr_alu <= raddr_alu + AW'(1);
                x_cnt     <= x_cnt + XW'(1);
            end
        end
    end

    // Read-latency delay line; frozen as a whole while stalled.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            pv <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pa[i] <= '0;
            end
        end else if (!stall) begin
            pv[0] <= issue;
            if (issue) begin
                pa[0] <= raddr_alu;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end

    assign waddr_alu = pa[RD_LAT-1];

    // Sticky overrun flag and completed-frame counter.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (start && state != S_IDLE) begin
                overrun <= 1'b1;
            end
            if (state == S_DONE) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule
